// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NG = WIDTH / GROUP;
  localparam int RW = 2 * GROUP + 1;

  if (GROUP < 1 || GROUP > 8 || WIDTH % GROUP != 0) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must be in 1..8");
  end

  // One slice of two-level lookahead: returns {carries c[GROUP:0], sum bits}
  function automatic logic [RW-1:0] cla_slice(input logic [GROUP-1:0] a, input logic [GROUP-1:0] b,
                                               input logic ci);
    logic [GROUP-1:0] p, g;
    logic [GROUP:0] c;
    logic t;
    p = a ^ b;
    g = a & b;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c, p ^ c[GROUP-1:0]};
  endfunction

  logic [NG-1:0]    v_q, v_d, c_q, c_d;
  logic [WIDTH-1:0] a_q [NG];
  logic [WIDTH-1:0] a_d [NG];
  logic [WIDTH-1:0] b_q [NG];
  logic [WIDTH-1:0] b_d [NG];
  logic [WIDTH-1:0] s_q [NG];
  logic [WIDTH-1:0] s_d [NG];
  logic [RW-1:0]    r   [NG];
  logic             out_v_q, out_v_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             adv;

  assign adv       = !out_v_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_v_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  // Subtraction is folded in at entry: invert B and force the carry-in
  assign v_d[0] = in_valid;
  assign a_d[0] = in_a;
  assign b_d[0] = in_sub ? ~in_b : in_b;
  assign c_d[0] = in_sub | in_cin;
  assign s_d[0] = '0;

  // Stage k resolves slice k; unresolved operand bits ride along (skew) and
  // resolved sum bits accumulate (deskew) so a whole result leaves together
  for (genvar k = 0; k < NG; k++) begin : g_stage
    assign r[k] = cla_slice(a_q[k][k*GROUP +: GROUP], b_q[k][k*GROUP +: GROUP], c_q[k]);
    if (k > 0) begin : g_link
      assign v_d[k] = v_q[k-1];
      assign a_d[k] = a_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign c_d[k] = r[k-1][RW-1];
      assign s_d[k] = s_q[k-1] | (WIDTH'(r[k-1][GROUP-1:0]) << ((k - 1) * GROUP));
    end
  end

  // Output register only reloads on a real result so cout/ovf keep their last value
  always_comb begin
    out_v_d = v_q[NG-1];
    sum_d   = v_q[NG-1] ? s_q[NG-1] | (WIDTH'(r[NG-1][GROUP-1:0]) << ((NG - 1) * GROUP)) : sum_q;
    cout_d  = v_q[NG-1] ? r[NG-1][RW-1] : cout_q;
    ovf_d   = v_q[NG-1] ? r[NG-1][RW-1] ^ r[NG-1][RW-2] : ovf_q;
  end

  // Whole pipe advances together or holds together on a downstream stall
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      c_q     <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      s_q     <= '{default: '0};
      out_v_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      v_q     <= v_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      out_v_q <= out_v_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for the pipelined lookahead adder (WIDTH=16, GROUP=4)
module tb_cla_pipe_adder;
  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NG = W / G;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
    int           st;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] in_a, in_b, out_sum;

  exp_t         sbq[$];
  exp_t         me;
  int           n_chk = 0, n_fail = 0, cyc = 0, stall_cnt = 0;
  logic         pstall = 1'b0, pcout, povf;
  logic [W-1:0] psum;

  cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: integer arithmetic on the operand values, not on bits
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 input logic sb);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sv = int'($signed(b));
    int u, t;
    if (sb) begin
      u = ua - ub;
      t = sa - sv;
      e.c = ua >= ub;
    end else begin
      u = ua + ub + int'(ci);
      t = sa + sv + int'(ci);
      e.c = u > 65535;
    end
    e.s = u[W-1:0];
    e.o = t > 32767 || t < -32768;
    e.acc = 0;
    e.st = 0;
    return e;
  endfunction

  task automatic send_e(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                        input exp_t e);
    int w = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = ci; in_sub = sb;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    e.acc = cyc;
    e.st  = stall_cnt;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    send_e(a, b, ci, sb, model(a, b, ci, sb));
  endtask

  task automatic sendk(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                       input logic [W-1:0] ks, input logic kc, input logic ko);
    exp_t e;
    e.s = ks; e.c = kc; e.o = ko; e.acc = 0; e.st = 0;
    send_e(a, b, ci, sb, e);
  endtask

  task automatic send_rand();
    send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every emitted result, checks hold-during-stall and handshake
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      pstall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (pstall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", out_sum, psum);
        chk("hold_cout", out_cout, pcout);
        chk("hold_ovf", out_ovf, povf);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("spurious_output", 1, 0);
        else begin
          me = sbq.pop_front();
          chk("sum", out_sum, me.s);
          chk("cout", out_cout, me.c);
          chk("ovf", out_ovf, me.o);
          chk("latency", cyc - me.acc - 1 - (stall_cnt - me.st), NG);
        end
      end
      pstall = out_valid && !out_ready;
      psum = out_sum; pcout = out_cout; povf = out_ovf;
      if (pstall) stall_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b1; in_sub = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    @(posedge clk); #1;

    sendk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain();
    sendk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();
    sendk(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();
    sendk(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    drain();
    sendk(16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) send_rand();
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send_rand();
          if (i == 3) begin
            repeat (2) @(posedge clk);
            #1;
          end
        end
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send_rand();
          if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("flush_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    sendk(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0123, 1'b1, 1'b0);
    drain();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
